// File: rtl/conv_arb_pkg.sv
`default_nettype none
// ------------------------------------------------------------------------
// conv_arb_pkg: shared types and limits for the conv SRAM arbiter.  Rev 1.0
// ------------------------------------------------------------------------
package conv_arb_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int BURST_MIN  = 1;
  localparam int BURST_MAX  = 255;
  localparam int LAT_MIN    = 1;
  localparam int LAT_MAX    = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  typedef logic master_id_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/conv_arb_rd_tag.sv
`default_nettype none
// ------------------------------------------------------------------------
// conv_arb_rd_tag: MEM_LAT-deep {valid, master id} pipe steering read data. Rev 1.0
// ------------------------------------------------------------------------
module conv_arb_rd_tag
  import conv_arb_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  master_id_t in_id,
  output logic       out_valid,
  output master_id_t out_id
);

  logic [MEM_LAT-1:0] vld_q;
  logic [MEM_LAT-1:0] id_q;

  generate
    if (MEM_LAT == 1) begin : g_single
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld_q <= '0;
          id_q  <= '0;
        end else begin
          vld_q[0] <= in_valid;
          id_q[0]  <= in_id;
        end
      end
    end else begin : g_multi
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld_q <= '0;
          id_q  <= '0;
        end else begin
          vld_q <= {vld_q[MEM_LAT-2:0], in_valid};
          id_q  <= {id_q[MEM_LAT-2:0], in_id};
        end
      end
    end
  endgenerate

  assign out_valid = vld_q[MEM_LAT-1];
  assign out_id    = id_q[MEM_LAT-1];

endmodule
`default_nettype wire

// File: rtl/conv_mem_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------------
// conv_mem_arbiter: round-robin, burst-capped sharing of one SRAM by two conv
// masters; CONV_ARB_STATS_EN adds beat/stall counters.  Rev 1.0
// ------------------------------------------------------------------------
module conv_mem_arbiter
  import conv_arb_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BURST = 8,
  parameter int MEM_LAT   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                S0_R_req,
  input  logic [DATA_W/8-1:0] S0_W_req,
  input  logic [ADDR_W-1:0]   S0_addr,
  input  logic [DATA_W-1:0]   S0_W_data,
  output logic                S0_gnt,
  output logic [DATA_W-1:0]   S0_R_data,
  output logic                S0_R_valid,
  input  logic                S1_R_req,
  input  logic [DATA_W/8-1:0] S1_W_req,
  input  logic [ADDR_W-1:0]   S1_addr,
  input  logic [DATA_W-1:0]   S1_W_data,
  output logic                S1_gnt,
  output logic [DATA_W-1:0]   S1_R_data,
  output logic                S1_R_valid,
  output logic                mem_R_req,
  output logic [DATA_W/8-1:0] mem_W_req,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_W_data,
  input  logic [DATA_W-1:0]   mem_R_data
`ifdef CONV_ARB_STATS_EN
  ,
  output logic [31:0]         stat_beats0,
  output logic [31:0]         stat_beats1,
  output logic [31:0]         stat_stall
`endif
);

  arb_state_t state;
  logic       rr;
  logic [7:0] beats;
  master_id_t mem_id;
  logic       req0, req1, burst_end;
  logic       tag_valid;
  master_id_t tag_id;

  assign req0      = S0_R_req | (|S0_W_req);
  assign req1      = S1_R_req | (|S1_W_req);
  assign S0_gnt    = (state == OWN0) & req0;
  assign S1_gnt    = (state == OWN1) & req1;
  assign burst_end = (beats == 8'(MAX_BURST - 1));

  // rr names the master preferred on the next tie seen from IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      rr    <= 1'b0;
      beats <= '0;
    end else begin
      case (state)
        IDLE: begin
          beats <= '0;
          if (req0 && (!req1 || !rr)) begin
            state <= OWN0;
            rr    <= 1'b1;
          end else if (req1) begin
            state <= OWN1;
            rr    <= 1'b0;
          end
        end
        OWN0: begin
          if (!req0 || burst_end) begin
            beats <= '0;
            if (req1) begin
              state <= OWN1;
              rr    <= 1'b0;
            end else if (!req0) begin
              state <= IDLE;
            end
          end else begin
            beats <= beats + 8'd1;
          end
        end
        OWN1: begin
          if (!req1 || burst_end) begin
            beats <= '0;
            if (req0) begin
              state <= OWN0;
              rr    <= 1'b1;
            end else if (!req1) begin
              state <= IDLE;
            end
          end else begin
            beats <= beats + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_R_req  <= 1'b0;
      mem_W_req  <= '0;
      mem_addr   <= '0;
      mem_W_data <= '0;
      mem_id     <= 1'b0;
    end else begin
      mem_R_req <= 1'b0;
      mem_W_req <= '0;
      if (S0_gnt) begin
        mem_R_req  <= S0_R_req;
        mem_W_req  <= S0_W_req;
        mem_addr   <= S0_addr;
        mem_W_data <= S0_W_data;
        mem_id     <= 1'b0;
      end else if (S1_gnt) begin
        mem_R_req  <= S1_R_req;
        mem_W_req  <= S1_W_req;
        mem_addr   <= S1_addr;
        mem_W_data <= S1_W_data;
        mem_id     <= 1'b1;
      end
    end
  end

  conv_arb_rd_tag #(
    .MEM_LAT (MEM_LAT)
  ) u_rd_tag (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (mem_R_req),
    .in_id     (mem_id),
    .out_valid (tag_valid),
    .out_id    (tag_id)
  );

  assign S0_R_data  = mem_R_data;
  assign S1_R_data  = mem_R_data;
  assign S0_R_valid = tag_valid & (tag_id == 1'b0);
  assign S1_R_valid = tag_valid & (tag_id == 1'b1);

`ifdef CONV_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_beats0 <= '0;
      stat_beats1 <= '0;
      stat_stall  <= '0;
    end else begin
      if (S0_gnt) stat_beats0 <= sat_inc(stat_beats0);
      if (S1_gnt) stat_beats1 <= sat_inc(stat_beats1);
      if ((req0 & ~S0_gnt) | (req1 & ~S1_gnt)) stat_stall <= sat_inc(stat_stall);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_conv_mem_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------------
// tb_conv_mem_arbiter: directed checks of conv_mem_arbiter with a 1-cycle SRAM model. Rev 1.0
// ------------------------------------------------------------------------
module tb_conv_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        S0_R_req, S1_R_req;
  logic [3:0]  S0_W_req, S1_W_req;
  logic [31:0] S0_addr, S1_addr, S0_W_data, S1_W_data;
  logic        S0_gnt, S1_gnt, S0_R_valid, S1_R_valid;
  logic [31:0] S0_R_data, S1_R_data;
  logic        mem_R_req;
  logic [3:0]  mem_W_req;
  logic [31:0] mem_addr, mem_W_data, mem_R_data;
`ifdef CONV_ARB_STATS_EN
  logic [31:0] stat_beats0, stat_beats1, stat_stall;
`endif

  int   total = 0;
  int   bad   = 0;
  int   waits = 0;
  logic e0;

  always #5 clk = ~clk;

  conv_mem_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .S0_R_req   (S0_R_req),
    .S0_W_req   (S0_W_req),
    .S0_addr    (S0_addr),
    .S0_W_data  (S0_W_data),
    .S0_gnt     (S0_gnt),
    .S0_R_data  (S0_R_data),
    .S0_R_valid (S0_R_valid),
    .S1_R_req   (S1_R_req),
    .S1_W_req   (S1_W_req),
    .S1_addr    (S1_addr),
    .S1_W_data  (S1_W_data),
    .S1_gnt     (S1_gnt),
    .S1_R_data  (S1_R_data),
    .S1_R_valid (S1_R_valid),
    .mem_R_req  (mem_R_req),
    .mem_W_req  (mem_W_req),
    .mem_addr   (mem_addr),
    .mem_W_data (mem_W_data),
    .mem_R_data (mem_R_data)
`ifdef CONV_ARB_STATS_EN
    ,
    .stat_beats0 (stat_beats0),
    .stat_beats1 (stat_beats1),
    .stat_stall  (stat_stall)
`endif
  );

  // SRAM model: read-during-write returns the old word
  logic [31:0] sram [0:1023];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) sram[i] <= 32'h0;
      sram[0]    <= 32'h0000_0011;
      sram[1]    <= 32'h0000_0022;
      sram[8]    <= 32'hCAFE_0001;
      mem_R_data <= 32'h0;
    end else begin
      if (mem_R_req) mem_R_data <= sram[mem_addr[11:2]];
      for (int b = 0; b < 4; b++)
        if (mem_W_req[b]) sram[mem_addr[11:2]][8*b +: 8] <= mem_W_data[8*b +: 8];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    S0_R_req = 1'b0; S0_W_req = 4'h0; S0_addr = 32'h0; S0_W_data = 32'h0;
    S1_R_req = 1'b0; S1_W_req = 4'h0; S1_addr = 32'h0; S1_W_data = 32'h0;
  endtask

  task automatic do_reset();
    clr_in();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] exp, input string tag);
    S0_R_req = 1'b1;
    S0_addr  = a;
    tick();
    tick();
    S0_R_req = 1'b0;
    tick();
    chk({tag, "_valid"}, 64'(S0_R_valid), 64'd1);
    chk({tag, "_data"}, 64'(S0_R_data), 64'(exp));
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clr_in();
    rst = 1'b1;
    tick();
    chk("rst_gnt0", 64'(S0_gnt), 64'd0);
    chk("rst_gnt1", 64'(S1_gnt), 64'd0);
    chk("rst_mrreq", 64'(mem_R_req), 64'd0);
    chk("rst_mwreq", 64'(mem_W_req), 64'd0);
    chk("rst_maddr", 64'(mem_addr), 64'd0);
    chk("rst_mwdata", 64'(mem_W_data), 64'd0);
    chk("rst_rv0", 64'(S0_R_valid), 64'd0);
    chk("rst_rv1", 64'(S1_R_valid), 64'd0);
    chk("rst_rdata", 64'(S0_R_data), 64'd0);
    rst = 1'b0;

    // single master, two back-to-back reads
    S0_R_req = 1'b1; S0_addr = 32'h000; #1;
    chk("t1_gnt_idle", 64'(S0_gnt), 64'd0);
    tick();
    chk("t1_gnt", 64'(S0_gnt), 64'd1);
    chk("t1_mreq_pre", 64'(mem_R_req), 64'd0);
    tick();
    chk("t1_mreq_a", 64'(mem_R_req), 64'd1);
    chk("t1_maddr_a", 64'(mem_addr), 64'h000);
    S0_addr = 32'h004;
    tick();
    chk("t1_rv_a", 64'(S0_R_valid), 64'd1);
    chk("t1_rd_a", 64'(S0_R_data), 64'h11);
    chk("t1_rv1_a", 64'(S1_R_valid), 64'd0);
    chk("t1_maddr_b", 64'(mem_addr), 64'h004);
    chk("t1_mreq_b", 64'(mem_R_req), 64'd1);
    S0_R_req = 1'b0;
    tick();
    chk("t1_rv_b", 64'(S0_R_valid), 64'd1);
    chk("t1_rd_b", 64'(S0_R_data), 64'h22);
    chk("t1_rv1_b", 64'(S1_R_valid), 64'd0);
    chk("t1_mreq_off", 64'(mem_R_req), 64'd0);
    tick();
    chk("t1_rv_end", 64'(S0_R_valid), 64'd0);

    // continuous contention: 8-beat alternation, no idle cycle
    do_reset();
    S0_R_req = 1'b1; S0_addr = 32'h100;
    S1_R_req = 1'b1; S1_addr = 32'h200; #1;
    chk("t2_gnt0_idle", 64'(S0_gnt), 64'd0);
    chk("t2_gnt1_idle", 64'(S1_gnt), 64'd0);
    waits = 1;
    tick();
    for (int k = 0; k < 32; k++) begin
      e0 = ((k / 8) % 2) == 0;
      chk("t2_gnt0", 64'(S0_gnt), 64'(e0));
      chk("t2_gnt1", 64'(S1_gnt), 64'(!e0));
      if (k >= 1) begin
        chk("t2_mreq", 64'(mem_R_req), 64'd1);
        chk("t2_maddr", 64'(mem_addr), (((k - 1) / 8) % 2 == 0) ? 64'h100 : 64'h200);
      end
      if (k >= 2) begin
        chk("t2_rv0", 64'(S0_R_valid), 64'(((k - 2) / 8) % 2 == 0));
        chk("t2_rv1", 64'(S1_R_valid), 64'(((k - 2) / 8) % 2 != 0));
      end
`ifdef CONV_ARB_STATS_EN
      if (k == 16) begin
        chk("stat_beats0", 64'(stat_beats0), 64'd8);
        chk("stat_beats1", 64'(stat_beats1), 64'd8);
        chk("stat_stall", 64'(stat_stall), 64'(waits));
      end
`endif
      waits++;
      tick();
    end
    clr_in();
    tick();
    tick();

    // S1 write lands at the first handover of an S0 read burst
    do_reset();
    S0_R_req = 1'b1; S0_addr = 32'h010;
    tick();
    S1_W_req = 4'hF; S1_addr = 32'h0C84; S1_W_data = 32'hDEAD_BEEF;
    for (int b = 0; b < 8; b++) begin
      chk("t3_gnt0_burst", 64'(S0_gnt), 64'd1);
      chk("t3_gnt1_wait", 64'(S1_gnt), 64'd0);
      tick();
    end
    S0_R_req = 1'b0; #1;
    chk("t3_gnt1", 64'(S1_gnt), 64'd1);
    chk("t3_gnt0_off", 64'(S0_gnt), 64'd0);
    tick();
    chk("t3_mwreq", 64'(mem_W_req), 64'hF);
    chk("t3_maddr", 64'(mem_addr), 64'h0C84);
    chk("t3_mwdata", 64'(mem_W_data), 64'hDEAD_BEEF);
    chk("t3_mrreq", 64'(mem_R_req), 64'd0);
    S1_W_req = 4'h0;
    tick();
    chk("t3_mwreq_off", 64'(mem_W_req), 64'h0);
    do_read(32'h0C84, 32'hDEAD_BEEF, "t3_rd");

    // combined read+write beat returns the old contents
    S0_R_req = 1'b1; S0_W_req = 4'hF; S0_addr = 32'h020; S0_W_data = 32'h1234_5678;
    tick();
    tick();
    chk("t4_mrreq", 64'(mem_R_req), 64'd1);
    chk("t4_mwreq", 64'(mem_W_req), 64'hF);
    clr_in();
    tick();
    chk("t4_rv", 64'(S0_R_valid), 64'd1);
    chk("t4_rd_old", 64'(S0_R_data), 64'hCAFE_0001);
    tick();
    do_read(32'h020, 32'h1234_5678, "t4_rd_new");

    // reset with a read in flight
    S0_R_req = 1'b1; S0_addr = 32'h000;
    tick();
    tick();
    chk("t5_inflight", 64'(mem_R_req), 64'd1);
    rst = 1'b1; #1;
    chk("t5_rv0", 64'(S0_R_valid), 64'd0);
    chk("t5_gnt0", 64'(S0_gnt), 64'd0);
    chk("t5_gnt1", 64'(S1_gnt), 64'd0);
    chk("t5_mrreq", 64'(mem_R_req), 64'd0);
    chk("t5_mwreq", 64'(mem_W_req), 64'h0);
    tick();
    chk("t5_rv0_later", 64'(S0_R_valid), 64'd0);
    rst = 1'b0;
    S1_R_req = 1'b1; S1_addr = 32'h200; #1;
    tick();
    chk("t5_first_gnt0", 64'(S0_gnt), 64'd1);
    chk("t5_first_gnt1", 64'(S1_gnt), 64'd0);
    clr_in();
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
